// File: rtl/data_mem_pkg.sv
// Default geometry for the frame-buffer data store.
package data_mem_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

endpackage : data_mem_pkg

// File: rtl/data_mem.sv
// Simple dual-port frame-buffer RAM. It has one write port and one read port on a
// single clock. The read is registered and read-first. The array has no reset, so
// it can map onto block RAM.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Read-port next value: fetch the addressed word on rd_en, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read register: reset clears only the output, never the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Write port: the array has no reset. A write that is blocked by reset leaves the contents unchanged.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Testbench for data_mem with a scoreboard. The driver predicts rd_data from a
// behavioural memory model. The monitor compares against the DUT on the falling edge.
module tb_data_mem;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    data_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] val;
        bit            chk;
        string         tag;
    } exp_t;

    exp_t sb[$];

    // Reference model: a word array plus flags for words that have been written.
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    logic [DW-1:0] ref_rd;
    bit            ref_rd_known;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // One clock of stimulus. The rd_data value expected after the edge goes to the scoreboard.
    task automatic cyc(input bit r, input bit we, input bit re,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                       input logic [DW-1:0] wd, input string tag);
        exp_t e;
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        rd_en   = re;
        wr_addr = wa;
        rd_addr = ra;
        wr_data = wd;
        @(posedge clk);
        if (r) begin
            ref_rd       = '0;
            ref_rd_known = 1'b1;
        end else begin
            if (re) begin
                ref_rd       = ref_mem[ra];
                ref_rd_known = ref_known[ra];
            end
            if (we) begin
                ref_mem[wa]   = wd;
                ref_known[wa] = 1'b1;
            end
        end
        e.val = ref_rd;
        e.chk = ref_rd_known;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: check each cycle's prediction against rd_data away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    checks++;
                    if (rd_data !== e.val) begin
                        errors++;
                        $display("FAIL %s: rd_data=%h expected %h at %0t", e.tag, rd_data, e.val, $time);
                    end
                end
            end
        end
    end

    // Stimulus: a directed test plan followed by a random mix.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        ref_rd       = '0;
        ref_rd_known = 1'b0;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        cyc(1, 0, 0, 3'd0, 3'd0, 16'h0000, "reset_init");
        cyc(1, 0, 0, 3'd0, 3'd0, 16'h0000, "reset_init");

        // A write then reset with rd_en high. The write blocked by reset must not land.
        cyc(0, 1, 0, 3'd0, 3'd0, 16'h00AA, "rst_wr");
        cyc(1, 1, 1, 3'd0, 3'd0, 16'hBEEF, "rst_rd_zero");
        cyc(0, 0, 1, 3'd0, 3'd0, 16'h0000, "rst_retain");
        cyc(0, 0, 0, 3'd0, 3'd0, 16'h0000, "rst_hold");

        // Sequential write and read.
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, AW'(i), 3'd0, DW'(i + 1), "seq_wr");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 3'd0, AW'(i), 16'h0000, "seq_rd");

        // With write disabled, the stored word must survive.
        cyc(0, 1, 0, 3'd5, 3'd0, 16'h0055, "wdis_wr");
        cyc(0, 0, 0, 3'd5, 3'd0, 16'hDEAD, "wdis_off");
        cyc(0, 0, 1, 3'd0, 3'd5, 16'h0000, "wdis_rd");

        // Read hold while rd_addr moves.
        cyc(0, 0, 1, 3'd0, 3'd1, 16'h0000, "hold_rd");
        cyc(0, 0, 0, 3'd0, 3'd2, 16'h0000, "hold_2");
        cyc(0, 0, 0, 3'd0, 3'd3, 16'h0000, "hold_3");

        // Same-address collision: the read returns the old word.
        cyc(0, 1, 0, 3'd7, 3'd0, 16'h1111, "coll_init");
        cyc(0, 1, 1, 3'd7, 3'd7, 16'h2222, "coll_old");
        cyc(0, 0, 1, 3'd0, 3'd7, 16'h0000, "coll_new");

        // Different-address read and write in the same cycle.
        cyc(0, 1, 1, 3'd6, 3'd2, 16'h6666, "dual_rd");
        cyc(0, 0, 1, 3'd0, 3'd6, 16'h0000, "dual_wr");

        // Full address range, with no aliasing between the end addresses.
        cyc(0, 1, 0, 3'd7, 3'd0, 16'hFFFF, "wrap_wr7");
        cyc(0, 1, 0, 3'd0, 3'd0, 16'h8000, "wrap_wr0");
        cyc(0, 0, 1, 3'd0, 3'd7, 16'h0000, "wrap_rd7");
        cyc(0, 0, 1, 3'd0, 3'd0, 16'h0000, "wrap_rd0");

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                AW'($urandom), AW'($urandom), DW'($urandom), "random");
        end

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        done = 1'b1;
    end

    // Summary once the scoreboard has drained. The time bound stops a hang.
    initial begin
        fork
            wait (done);
            #200000;
        join_any
        if (!done) begin
            errors++;
            $display("FAIL timeout: done=%0d expected 1", done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_mem

// File: doc/data_mem.md
Name: data_mem

Overview:
Simple dual-port synchronous RAM used as a frame-buffer data store: one write port and one independent read port, both on a single clock. Writes commit on the rising edge; reads are registered (1-cycle latency). Sits between the pixel-producing logic (write side) and the display/readout logic (read side).

Parameters:
DATA_WIDTH, 16, width of each memory word in bits
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write enable, active-high
rd_en  input  1  read enable, active-high
wr_addr  input  ADDR_WIDTH  write address
rd_addr  input  ADDR_WIDTH  read address
wr_data  input  DATA_WIDTH  write data
rd_data  output  DATA_WIDTH  registered read data

Behaviour:
- One clock; reset is synchronous and active-high (port names clk, reset).
- Storage: array of 2**ADDR_WIDTH words of DATA_WIDTH bits; full address range valid, no out-of-range case.
- Reset (reset=1 at rising edge): rd_data <= 0; writes and reads that cycle are ignored; array contents are NOT cleared (undefined after power-up, retained across reset).
- Reset has priority over wr_en and rd_en.
- Write: reset=0 and wr_en=1 at rising edge -> mem[wr_addr] <= wr_data. wr_en=0 -> array unchanged.
- Read: reset=0 and rd_en=1 at rising edge -> rd_data <= mem[rd_addr]; value visible after that edge (1-cycle latency).
- rd_en=0 -> rd_data holds its previous value.
- Read and write same cycle, different addresses: both complete independently.
- Read and write same cycle, same address: read-first; rd_data gets the OLD word, new word is visible to a read issued on the next cycle.
- Reset asserted mid-sequence: rd_data forced to 0 on that edge; previously written data remains readable after reset deasserts.
- No handshake, no back-pressure; accepts one write and one read every cycle.
- Combinational paths: none from inputs to rd_data (fully registered output).
- Must infer to a simple dual-port block RAM (no reset on the array).

Decomposition:
- No shared package required; DATA_WIDTH/ADDR_WIDTH are module parameters only.
- Flat single module; no sub-modules.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=3):
- Reset: write 16'h00AA to addr 0, assert reset one cycle with rd_en=1 -> rd_data=16'h0000; deassert, read addr 0 -> 16'h00AA one cycle later.
- Sequential write/read: write 16'h0001..16'h0004 to addr 0..3, then read addr 0..3 with rd_en=1 -> rd_data 16'h0001..16'h0004, each one cycle after the address is presented.
- Write disabled: wr_en=0, wr_addr=5, wr_data=16'hDEAD -> subsequent read of addr 5 returns its prior contents (write 16'h0055 first, expect 16'h0055).
- Read hold: read addr 1 (16'h0002), then rd_en=0 while rd_addr moves to 2,3 -> rd_data stays 16'h0002.
- Same-address collision: mem[7]=16'h1111; in one cycle write 16'h2222 to addr 7 and read addr 7 -> rd_data=16'h1111; read addr 7 next cycle -> 16'h2222.
- Wrap/full range: write addr 7 = 16'hFFFF and addr 0 = 16'h8000, read both -> exact values, no aliasing.
